// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu: operation request handshake, operands,
// registered result and condition flags.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic [3:0]       alufun;
    logic             setCC;
    logic             out_valid;
    logic [WIDTH-1:0] valE;
    logic             ZF;
    logic             SF;
    logic             OF;
    logic             CF;

    // Requester side: drives operations, observes results.
    modport master (
        output in_valid, aluA, aluB, alufun, setCC,
        input  in_ready, out_valid, valE, ZF, SF, OF, CF
    );

    // ALU side: accepts operations, produces results.
    modport slave (
        input  in_valid, aluA, aluB, alufun, setCC,
        output in_ready, out_valid, valE, ZF, SF, OF, CF
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/shift operations and a
// multi-cycle shift-add unsigned multiply (one multiplier bit per cycle).
// Results and flags are registered; out_valid pulses once per operation.
module seq_alu #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpXor = 4'd3;
    localparam logic [3:0] OpOr  = 4'd4;
    localparam logic [3:0] OpShl = 4'd5;
    localparam logic [3:0] OpShr = 4'd6;
    localparam logic [3:0] OpSar = 4'd7;
    localparam logic [3:0] OpMul = 4'd8;

    localparam logic [SHW-1:0] LastStep = SHW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } state_e;

    state_e             state_q;
    logic [SHW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               setcc_q;

    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_of;
    logic               alu_cf;
    logic               alu_known;
    logic [2*WIDTH-1:0] acc_step;
    logic               mul_hi_nz;

    assign bus.in_ready = (state_q == StIdle);

    assign add_full = {1'b0, bus.aluA} + {1'b0, bus.aluB};
    // Top bit of the widened difference is the unsigned borrow.
    assign sub_full = {1'b0, bus.aluA} - {1'b0, bus.aluB};
    assign shamt    = bus.aluB[SHW-1:0];

    // Single-cycle result and flag candidates from the live request operands.
    always_comb begin
        alu_res   = '0;
        alu_of    = 1'b0;
        alu_cf    = 1'b0;
        alu_known = 1'b1;
        unique case (bus.alufun)
            OpAdd: begin
                alu_res = add_full[WIDTH-1:0];
                alu_cf  = add_full[WIDTH];
                alu_of  = (bus.aluA[WIDTH-1] == bus.aluB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.aluA[WIDTH-1]);
            end
            OpSub: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_cf  = sub_full[WIDTH];
                alu_of  = (bus.aluA[WIDTH-1] != bus.aluB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.aluA[WIDTH-1]);
            end
            OpAnd:   alu_res = bus.aluA & bus.aluB;
            OpXor:   alu_res = bus.aluA ^ bus.aluB;
            OpOr:    alu_res = bus.aluA | bus.aluB;
            OpShl:   alu_res = bus.aluA << shamt;
            OpShr:   alu_res = bus.aluA >> shamt;
            OpSar:   alu_res = WIDTH'($signed(bus.aluA) >>> shamt);
            default: alu_known = 1'b0;
        endcase
    end

    // One shift-add multiply step: add the shifted multiplicand if the
    // current multiplier bit is set.
    always_comb begin
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_hi_nz = |acc_step[2*WIDTH-1:WIDTH];
    end

    // Control FSM with registered result, flags and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            setcc_q       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.valE      <= '0;
            bus.ZF        <= 1'b0;
            bus.SF        <= 1'b0;
            bus.OF        <= 1'b0;
            bus.CF        <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // in_ready is high in this state, so in_valid means accept.
                    if (bus.in_valid) begin
                        if (bus.alufun == OpMul) begin
                            state_q  <= StMul;
                            cnt_q    <= '0;
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, bus.aluA};
                            mplier_q <= bus.aluB;
                            setcc_q  <= bus.setCC;
                        end else if (alu_known) begin
                            bus.valE      <= alu_res;
                            bus.out_valid <= 1'b1;
                            if (bus.setCC) begin
                                bus.ZF <= (alu_res == '0);
                                bus.SF <= alu_res[WIDTH-1];
                                bus.OF <= alu_of;
                                bus.CF <= alu_cf;
                            end
                        end else begin
                            // Undefined opcode: zero result, flags untouched.
                            bus.valE      <= '0;
                            bus.out_valid <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastStep) begin
                        state_q       <= StIdle;
                        bus.valE      <= acc_step[WIDTH-1:0];
                        bus.out_valid <= 1'b1;
                        if (setcc_q) begin
                            bus.ZF <= (acc_step[WIDTH-1:0] == '0);
                            bus.SF <= acc_step[WIDTH-1];
                            bus.OF <= mul_hi_nz;
                            bus.CF <= mul_hi_nz;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath width in bits, minimum 4, power of 2.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH): shift-amount width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operation request.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-007 SHALL have port aluA, input, WIDTH bits: operand A.
REQ-008 SHALL have port aluB, input, WIDTH bits: operand B; its low SHW bits are the shift amount for shift operations.
REQ-009 SHALL have port alufun, input, 4 bits: operation code.
REQ-010 SHALL have port setCC, input, 1 bit: the operation updates the flags.
REQ-011 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-012 SHALL have port valE, output, WIDTH bits: registered result.
REQ-013 SHALL have ports ZF, SF, OF and CF, outputs, 1 bit each: registered zero, sign, signed-overflow and carry/borrow flags.

Function
REQ-014 Acceptance SHALL occur at a rising edge where in_valid=1 and in_ready=1; aluA, aluB, alufun and setCC SHALL be captured at that edge.
REQ-015 in_ready SHALL be combinational and equal 1 exactly when the state is IDLE.
REQ-016 The state machine SHALL have two states: IDLE and MUL.
REQ-017 Opcodes: 0 add; 1 sub (A-B); 2 and; 3 xor; 4 or; 5 shl; 6 shr logical; 7 sar arithmetic; 8 mul (unsigned, low WIDTH bits of the product).
REQ-018 Opcodes 9-15 SHALL produce valE=0, SHALL leave all flags unchanged regardless of setCC, and SHALL still pulse out_valid.
REQ-019 For opcodes 0-7 accepted in IDLE, valE and out_valid=1 SHALL be registered at the acceptance edge (latency 1 cycle), and the state SHALL remain IDLE.
REQ-020 For opcode 8, the acceptance edge SHALL enter MUL with iteration counter 0; each MUL cycle SHALL perform one shift-add step (one bit of B); the counter SHALL increment each cycle.
REQ-021 On the edge completing step WIDTH-1, the block SHALL load valE, update the flags, set out_valid=1 and return to IDLE; in_ready SHALL therefore be low for exactly WIDTH cycles.
REQ-022 out_valid SHALL be high for exactly one cycle per accepted operation; there SHALL be no output backpressure.
REQ-023 valE SHALL hold its value between results.
REQ-024 in_valid while in_ready=0 SHALL be ignored and no operands captured.
REQ-025 Shift amounts SHALL use aluB[SHW-1:0] only; an amount of 0 SHALL return aluA unchanged.
REQ-026 Add and sub SHALL use modulo-2^WIDTH arithmetic.
REQ-027 Flags SHALL be written only at result completion and only if the captured setCC=1; otherwise ZF, SF, OF and CF SHALL hold.
REQ-028 ZF SHALL be set to (valE==0) and SF SHALL be set to valE[WIDTH-1].
REQ-029 For add, OF SHALL be 1 when the operand signs are equal and the result sign differs; CF SHALL be the carry-out.
REQ-030 For sub, OF SHALL be 1 when the operand signs differ and the result sign differs from A; CF SHALL be 1 when A<B unsigned (borrow).
REQ-031 For mul, OF and CF SHALL both be 1 when the upper WIDTH bits of the full product are nonzero.
REQ-032 For opcodes 2-7, OF and CF SHALL be 0.

Reset
REQ-033 While rst=1 at an edge, the state SHALL go to IDLE and the counter to 0.
REQ-034 While rst=1 at an edge, valE SHALL go to 0, out_valid to 0, and ZF, SF, OF and CF to 0.
REQ-035 Reset during MUL SHALL abandon the operation with no out_valid pulse; in_ready SHALL be 1 in the cycle after rst is deasserted.
REQ-036 rst SHALL take priority over acceptance in the same cycle.

Verification (WIDTH=16)
REQ-037 add 0x7FFF+0x0001, setCC=1 -> next cycle valE=0x8000, out_valid=1, ZF=0, SF=1, OF=1, CF=0.
REQ-038 sub 0x0005-0x0005, setCC=1, then xor 0x00F0^0x000F with setCC=0 -> valE=0x0000 with ZF=1, CF=0; then valE=0x00FF with flags unchanged (ZF=1).
REQ-039 sar 0x8000 by aluB=0x0013 -> amount 3, valE=0xF000; shl 0x0001 by amount 0 -> valE=0x0001.
REQ-040 mul 0x0100*0x0100, setCC=1 -> in_ready=0 for 16 cycles, an in_valid issued mid-operation is ignored, then valE=0x0000, ZF=1, OF=1, CF=1, with one out_valid pulse.
REQ-041 mul 0x0003*0x0005 with rst asserted at the 8th MUL cycle -> no out_valid, all outputs 0, in_ready=1 after reset; a new add 2+3 -> valE=0x0005.
REQ-042 alufun=0xF, setCC=1 after a prior ZF=1 -> valE=0, out_valid pulses, ZF stays 1.
